// File: rtl/stump_bus_interface_pkg.sv
// Shared Stump memory-interface definitions: FSM states, access kinds and defaults.
package stump_bus_interface_pkg;

    typedef enum logic {
        BI_IDLE   = 1'b0,
        BI_ACCESS = 1'b1
    } bi_state_e;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } bi_kind_e;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int DEFAULT_CNT_W   = 4;

    // Fetch wins over store, store over load; ren+wen together is a store.
    function automatic bi_kind_e decode_kind(input logic fetch, input logic mem_wen);
        if (fetch)
            return KIND_FETCH;
        else if (mem_wen)
            return KIND_STORE;
        else
            return KIND_LOAD;
    endfunction

endpackage

// File: rtl/stump_bus_wait_counter.sv
// Saturating wait-state counter; flags when the count reaches TIMEOUT (never when TIMEOUT is 0).
module stump_bus_wait_counter #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst)
            count_reg <= '0;
        else if (clr)
            count_reg <= '0;
        else if (en && (count_reg != CNT_MAX))
            count_reg <= count_reg + 1'b1;
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = (count_reg == TIMEOUT_V);
        end
    endgenerate

endmodule

// File: rtl/stump_bus_interface.sv
// Stump memory-side stage: turns fetch/load/store requests into a registered,
// ready-handshaked bus access, stalls the core meanwhile and captures ir/mdr.
module stump_bus_interface
    import stump_bus_interface_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic              memory,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ea,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_re,
    output logic              bus_we,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              bus_err
);

    bi_state_e         state_reg, state_next;
    bi_kind_e          kind_reg, kind_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
    logic              bus_re_reg, bus_re_next;
    logic              bus_we_reg, bus_we_next;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic [DATA_W-1:0] mdr_reg, mdr_next;
    logic              bus_err_reg, bus_err_next;

    logic req_fetch, req_st, req_ld, req;
    logic timeout_hit;
    logic wait_en;

    assign req_fetch = fetch;
    assign req_st    = memory & mem_wen & ~fetch;
    assign req_ld    = memory & mem_ren & ~mem_wen & ~fetch;
    assign req       = req_fetch | req_st | req_ld;

    assign wait_en = (state_reg == BI_ACCESS) & ~bus_ready & ~timeout_hit;

    stump_bus_wait_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk         (clk),
        .rst         (rst),
        .clr         (state_reg == BI_IDLE),
        .en          (wait_en),
        .timeout_hit (timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= BI_IDLE;
            kind_reg      <= KIND_FETCH;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_re_reg    <= 1'b0;
            bus_we_reg    <= 1'b0;
            ir_reg        <= '0;
            mdr_reg       <= '0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            kind_reg      <= kind_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            bus_re_reg    <= bus_re_next;
            bus_we_reg    <= bus_we_next;
            ir_reg        <= ir_next;
            mdr_reg       <= mdr_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        kind_next      = kind_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        bus_re_next    = bus_re_reg;
        bus_we_next    = bus_we_reg;
        ir_next        = ir_reg;
        mdr_next       = mdr_reg;
        bus_err_next   = bus_err_reg;

        case (state_reg)
            BI_IDLE: begin
                if (req) begin
                    bus_addr_next = req_fetch ? pc : ea;
                    if (req_st)
                        bus_wdata_next = st_data;
                    bus_re_next = req_fetch | req_ld;
                    bus_we_next = req_st;
                    kind_next   = decode_kind(fetch, mem_wen);
                    state_next  = BI_ACCESS;
                end else begin
                    bus_re_next = 1'b0;
                    bus_we_next = 1'b0;
                end
            end
            BI_ACCESS: begin
                if (bus_ready) begin
                    case (kind_reg)
                        KIND_FETCH: ir_next  = bus_rdata;
                        KIND_LOAD:  mdr_next = bus_rdata;
                        default:    ;
                    endcase
                    bus_re_next = 1'b0;
                    bus_we_next = 1'b0;
                    state_next  = BI_IDLE;
                end else if (timeout_hit) begin
                    // Abandon the access; the core resumes and the error stays latched.
                    bus_re_next  = 1'b0;
                    bus_we_next  = 1'b0;
                    bus_err_next = 1'b1;
                    state_next   = BI_IDLE;
                end
            end
        endcase
    end

    assign stall = ((state_reg == BI_IDLE) & req) |
                   ((state_reg == BI_ACCESS) & ~bus_ready & ~timeout_hit);

    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_re    = bus_re_reg;
    assign bus_we    = bus_we_reg;
    assign ir        = ir_reg;
    assign mdr       = mdr_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_stump_bus_interface.sv
// Directed checks of the Stump bus interface: reset, fetch, load/store, back-to-back, timeout, mid-access reset.
module tb_stump_bus_interface;

    logic        clk;
    logic        rst;
    logic        fetch, memory, mem_ren, mem_wen;
    logic [15:0] pc, ea, st_data, bus_rdata;
    logic        bus_ready;
    logic [15:0] bus_addr, bus_wdata, ir, mdr;
    logic        bus_re, bus_we, stall, bus_err;

    int checks = 0;
    int errors = 0;

    stump_bus_interface dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fetch),
        .memory    (memory),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .pc        (pc),
        .ea        (ea),
        .st_data   (st_data),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_re    (bus_re),
        .bus_we    (bus_we),
        .ir        (ir),
        .mdr       (mdr),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b0; fetch = 1'b1; memory = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        pc = 16'hABCD; ea = 16'h0000; st_data = 16'h0000;
        bus_rdata = 16'h9999; bus_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", stall); end
        checks++; if (bus_re !== 1'b0 || bus_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: got re=%b we=%b expected 0 0", bus_re, bus_we); end
        checks++; if (bus_addr !== 16'h0 || bus_wdata !== 16'h0) begin errors++; $display("FAIL reset_bus: got addr=%h wdata=%h expected 0000 0000", bus_addr, bus_wdata); end
        checks++; if (ir !== 16'h0 || mdr !== 16'h0 || bus_err !== 1'b0) begin errors++; $display("FAIL reset_regs: got ir=%h mdr=%h err=%b expected 0000 0000 0", ir, mdr, bus_err); end
        rst = 1'b1; bus_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus_re !== 1'b1 || bus_addr !== 16'hABCD) begin errors++; $display("FAIL reset_release_access: got re=%b addr=%h expected 1 abcd", bus_re, bus_addr); end
        bus_ready = 1'b1; fetch = 1'b0;
        @(negedge clk); #1;
        bus_ready = 1'b0;
        checks++; if (ir !== 16'h9999) begin errors++; $display("FAIL reset_release_ir: got %h expected 9999", ir); end
        $display("reset: released, first fetch addr=abcd ir=%h", ir);
    endtask

    task automatic test_fetch_zero_wait();
        @(negedge clk);
        fetch = 1'b1; pc = 16'h0010; bus_rdata = 16'hA5C3;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fetch0_req_stall: got %b expected 1", stall); end
        @(negedge clk);
        bus_ready = 1'b1; fetch = 1'b0;
        #1;
        checks++; if (bus_re !== 1'b1 || bus_addr !== 16'h0010) begin errors++; $display("FAIL fetch0_bus: got re=%b addr=%h expected 1 0010", bus_re, bus_addr); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fetch0_done_stall: got %b expected 0", stall); end
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        checks++; if (ir !== 16'hA5C3 || bus_re !== 1'b0) begin errors++; $display("FAIL fetch0_ir: got ir=%h re=%b expected a5c3 0", ir, bus_re); end
        $display("fetch: pc=0010 ir=%h", ir);
    endtask

    task automatic test_load_wait();
        int stall_cycles;
        stall_cycles = 0;
        @(negedge clk);
        memory = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; ea = 16'h8000; bus_rdata = 16'h1234;
        #1;
        if (stall === 1'b1) stall_cycles++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (stall === 1'b1) stall_cycles++;
            checks++; if (bus_re !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 16'h8000) begin errors++; $display("FAIL load_wait_bus[%0d]: got re=%b we=%b addr=%h expected 1 0 8000", i, bus_re, bus_we, bus_addr); end
        end
        @(negedge clk);
        bus_ready = 1'b1; memory = 1'b0; mem_ren = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_done_stall: got %b expected 0", stall); end
        checks++; if (stall_cycles !== 4) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 4", stall_cycles); end
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        checks++; if (mdr !== 16'h1234 || ir !== 16'hA5C3 || bus_we !== 1'b0) begin errors++; $display("FAIL load_capture: got mdr=%h ir=%h we=%b expected 1234 a5c3 0", mdr, ir, bus_we); end
        $display("load: ea=8000 waits=3 mdr=%h", mdr);
    endtask

    task automatic test_store_conflict();
        @(negedge clk);
        memory = 1'b1; mem_ren = 1'b1; mem_wen = 1'b1; ea = 16'h0042; st_data = 16'hBEEF;
        bus_rdata = 16'h5555;
        @(negedge clk);
        bus_ready = 1'b1; memory = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; st_data = 16'h0000;
        #1;
        checks++; if (bus_we !== 1'b1 || bus_re !== 1'b0) begin errors++; $display("FAIL store_strobes: got we=%b re=%b expected 1 0", bus_we, bus_re); end
        checks++; if (bus_wdata !== 16'hBEEF || bus_addr !== 16'h0042) begin errors++; $display("FAIL store_bus: got wdata=%h addr=%h expected beef 0042", bus_wdata, bus_addr); end
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        checks++; if (mdr !== 16'h1234 || bus_we !== 1'b0 || bus_wdata !== 16'hBEEF) begin errors++; $display("FAIL store_after: got mdr=%h we=%b wdata=%h expected 1234 0 beef", mdr, bus_we, bus_wdata); end
        $display("store: ea=0042 wdata=%h mdr=%h", bus_wdata, mdr);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        fetch = 1'b1; pc = 16'h0020; bus_rdata = 16'h1111;
        @(negedge clk);
        bus_ready = 1'b1; fetch = 1'b0;
        @(negedge clk);
        bus_ready = 1'b0; memory = 1'b1; mem_ren = 1'b1; ea = 16'h0030; bus_rdata = 16'h2222;
        #1;
        checks++; if (stall !== 1'b1 || bus_re !== 1'b0 || ir !== 16'h1111) begin errors++; $display("FAIL b2b_idle: got stall=%b re=%b ir=%h expected 1 0 1111", stall, bus_re, ir); end
        @(negedge clk);
        bus_ready = 1'b1; memory = 1'b0; mem_ren = 1'b0;
        #1;
        checks++; if (bus_re !== 1'b1 || bus_addr !== 16'h0030 || stall !== 1'b0) begin errors++; $display("FAIL b2b_access: got re=%b addr=%h stall=%b expected 1 0030 0", bus_re, bus_addr, stall); end
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        checks++; if (mdr !== 16'h2222 || ir !== 16'h1111) begin errors++; $display("FAIL b2b_capture: got mdr=%h ir=%h expected 2222 1111", mdr, ir); end
        $display("back_to_back: fetch ir=%h then load mdr=%h", ir, mdr);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        fetch = 1'b1; pc = 16'h0100; bus_rdata = 16'hFFFF;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            pc = 16'h0F0F;
            if (k == 16) fetch = 1'b0;
            #1;
            if (k == 8) begin
                checks++; if (bus_addr !== 16'h0100 || bus_re !== 1'b1) begin errors++; $display("FAIL timeout_hold: got addr=%h re=%b expected 0100 1", bus_addr, bus_re); end
            end
            if (k == 15) begin
                checks++; if (stall !== 1'b1) begin errors++; $display("FAIL timeout_cycle15_stall: got %b expected 1", stall); end
            end
            if (k == 16) begin
                checks++; if (stall !== 1'b0) begin errors++; $display("FAIL timeout_abort_stall: got %b expected 0", stall); end
            end
        end
        @(negedge clk); #1;
        checks++; if (bus_err !== 1'b1 || ir !== 16'h1111 || bus_re !== 1'b0) begin errors++; $display("FAIL timeout_abort: got err=%b ir=%h re=%b expected 1 1111 0", bus_err, ir, bus_re); end
        fetch = 1'b1; pc = 16'h0200; bus_rdata = 16'h7777;
        @(negedge clk);
        bus_ready = 1'b1; fetch = 1'b0;
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        checks++; if (ir !== 16'h7777 || bus_err !== 1'b1) begin errors++; $display("FAIL timeout_recover: got ir=%h err=%b expected 7777 1", ir, bus_err); end
        $display("timeout: aborted fetch err=%b, next fetch ir=%h", bus_err, ir);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        memory = 1'b1; mem_ren = 1'b1; ea = 16'h1111; bus_rdata = 16'h4321;
        @(negedge clk);
        memory = 1'b0; mem_ren = 1'b0;
        @(negedge clk);
        rst = 1'b0; bus_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus_re !== 1'b0 || bus_we !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL midrst_idle: got re=%b we=%b stall=%b expected 0 0 0", bus_re, bus_we, stall); end
        checks++; if (mdr !== 16'h0 || bus_err !== 1'b0 || ir !== 16'h0) begin errors++; $display("FAIL midrst_regs: got mdr=%h err=%b ir=%h expected 0000 0 0000", mdr, bus_err, ir); end
        rst = 1'b1; bus_ready = 1'b0;
        @(negedge clk); #1;
        checks++; if (mdr !== 16'h0 || bus_re !== 1'b0) begin errors++; $display("FAIL midrst_after: got mdr=%h re=%b expected 0000 0", mdr, bus_re); end
        $display("mid_reset: load ea=1111 aborted by reset, mdr=%h err=%b", mdr, bus_err);
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_load_wait();
        test_store_conflict();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
